// File: rtl/bt_timer_apb_slv.sv
// bt_timer_apb_slv: APB slave wrapping a prescaled 32-bit down-counting timer.
//
// Ports:
//   pclkg            sole clock, rising edge
//   presetn          asynchronous active-low reset
//   psel/penable     APB select / access phase
//   pwrite           1 = write, 0 = read
//   paddr[11:2]      word address
//   pwdata[31:0]     write data
//   prdata[31:0]     read data, non-zero only in the read completion cycle
//   pready           low only in the first access cycle of a read
//   pslverr          high in the completing cycle of an unmapped access
//   timer_irq        registered level interrupt (IRQF & IRQEN)
//
// Register map (byte offset):
//   0x000 CTRL      {ONESHOT, IRQEN, EN}
//   0x004 VALUE
//   0x008 RELOAD
//   0x00C INTSTATUS {IRQF}, write-1-to-clear
//   0x010 PRESCALE
//
// Read FSM:
//   state   | meaning
//   IDLE    | no read outstanding, pready=1
//   RD_PEND | read data captured, completing the transfer this cycle
module bt_timer_apb_slv #(
    parameter int PRESCALE_W = 8
) (
    input  logic        pclkg,
    input  logic        presetn,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [11:2] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        timer_irq
);

    typedef enum logic {IDLE, RD_PEND} state_t;

    state_t                state;
    logic [31:0]           rd_buf;
    logic                  rd_err;

    logic                  ctrl_en;
    logic                  ctrl_irqen;
    logic                  ctrl_oneshot;
    logic                  irqf;
    logic [31:0]           value;
    logic [31:0]           reload;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] pre_cnt;

    logic                  wr_acc;
    logic                  rd_start;
    logic                  addr_bad;
    logic                  tick;
    logic                  expire;
    logic [31:0]           rd_mux;

    assign wr_acc   = psel & penable & pwrite;
    assign rd_start = (state == IDLE) & psel & penable & ~pwrite;
    assign addr_bad = (paddr > 10'd4);
    assign tick     = ctrl_en & (pre_cnt == prescale);
    assign expire   = tick & (value == 32'd0);

    always_comb begin
        rd_mux = 32'd0;
        case (paddr)
            10'd0:   rd_mux = {29'd0, ctrl_oneshot, ctrl_irqen, ctrl_en};
            10'd1:   rd_mux = value;
            10'd2:   rd_mux = reload;
            10'd3:   rd_mux = {31'd0, irqf};
            10'd4:   rd_mux = {{(32-PRESCALE_W){1'b0}}, prescale};
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge pclkg or negedge presetn) begin
        if (!presetn) begin
            state  <= IDLE;
            rd_buf <= 32'd0;
            rd_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_start) begin
                        state  <= RD_PEND;
                        rd_buf <= addr_bad ? 32'd0 : rd_mux;
                        rd_err <= addr_bad;
                    end
                end
                RD_PEND: begin
                    state  <= IDLE;
                    rd_buf <= 32'd0;
                    rd_err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A master that drops psel during the pending cycle sees an empty, error-free completion.
    assign pready  = ~rd_start;
    assign prdata  = ((state == RD_PEND) && psel) ? rd_buf : 32'd0;
    assign pslverr = (state == RD_PEND) ? (psel & rd_err) : (wr_acc & addr_bad);

    always_ff @(posedge pclkg or negedge presetn) begin
        if (!presetn) begin
            pre_cnt      <= '0;
            prescale     <= '0;
            value        <= 32'd0;
            reload       <= 32'd0;
            ctrl_en      <= 1'b0;
            ctrl_irqen   <= 1'b0;
            ctrl_oneshot <= 1'b0;
            irqf         <= 1'b0;
            timer_irq    <= 1'b0;
        end else begin
            if (!ctrl_en || tick) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + PRESCALE_W'(1);
            end

            // Bus writes take priority over the timer's own updates in the same cycle.
            if (wr_acc && paddr == 10'd1) begin
                value <= pwdata;
            end else if (tick) begin
                if (value != 32'd0) begin
                    value <= value - 32'd1;
                end else if (!ctrl_oneshot) begin
                    value <= reload;
                end
            end

            if (wr_acc && paddr == 10'd0) begin
                ctrl_en      <= pwdata[0];
                ctrl_irqen   <= pwdata[1];
                ctrl_oneshot <= pwdata[2];
            end else if (expire && ctrl_oneshot) begin
                ctrl_en <= 1'b0;
            end

            if (wr_acc && paddr == 10'd2) begin
                reload <= pwdata;
            end

            if (wr_acc && paddr == 10'd4) begin
                prescale <= pwdata[PRESCALE_W-1:0];
            end

            // A new expiry outranks a simultaneous clear so no event is lost.
            if (expire) begin
                irqf <= 1'b1;
            end else if (wr_acc && paddr == 10'd3 && pwdata[0]) begin
                irqf <= 1'b0;
            end

            timer_irq <= irqf & ctrl_irqen;
        end
    end

endmodule

// File: tb/tb_bt_timer_apb_slv.sv
module tb_bt_timer_apb_slv;

    localparam logic [11:2] A_CTRL   = 10'd0;
    localparam logic [11:2] A_VALUE  = 10'd1;
    localparam logic [11:2] A_RELOAD = 10'd2;
    localparam logic [11:2] A_INT    = 10'd3;
    localparam logic [11:2] A_PRE    = 10'd4;

    logic        pclkg = 1'b0;
    logic        presetn;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:2] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        timer_irq;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    logic [31:0] exp_reg [5];

    // Timer reference: ticks land every (P+1) edges after the enabling edge;
    // the count walks vbase..0 then R..0 repeatedly (one-shot parks at 0).
    int     m_e0, m_p, m_r, m_clr, m_kbase;
    longint m_vbase;
    bit     m_os;

    bt_timer_apb_slv #(.PRESCALE_W(8)) dut (
        .pclkg     (pclkg),
        .presetn   (presetn),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .timer_irq (timer_irq)
    );

    always #5 pclkg = ~pclkg;
    always @(posedge pclkg) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int ticks_at(input int e);
        if (e <= m_e0) return 0;
        return (e - m_e0) / (m_p + 1);
    endfunction

    function automatic bit is_tick(input int e);
        return (e > m_e0) && ((e - m_e0) % (m_p + 1) == 0);
    endfunction

    function automatic longint val_at(input int e);
        longint k;
        k = longint'(ticks_at(e) - m_kbase);
        if (k <= m_vbase) return m_vbase - k;
        if (m_os) return 0;
        return longint'(m_r) - ((k - m_vbase - 1) % (m_r + 1));
    endfunction

    function automatic bit reload_k(input int k);
        longint j;
        j = longint'(k - m_kbase);
        if (j <= m_vbase) return 0;
        if (m_os) return j == m_vbase + 1;
        return ((j - m_vbase - 1) % (m_r + 1)) == 0;
    endfunction

    function automatic bit irqf_at(input int e);
        for (int k = 1; k <= ticks_at(e); k++)
            if (m_e0 + k * (m_p + 1) >= m_clr && reload_k(k)) return 1;
        return 0;
    endfunction

    function automatic bit en_at(input int e);
        return !m_os || (longint'(ticks_at(e) - m_kbase) <= m_vbase);
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge pclkg); #1; end
    endtask

    // Called at posedge+1; e_out is the edge that commits the write.
    task automatic apb_wr(input logic [11:2] a, input logic [31:0] d,
                          output logic rdy, output logic err, output int e_out);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge pclkg); #1; penable = 1'b1;
        @(negedge pclkg); rdy = pready; err = pslverr;
        @(posedge pclkg); #1; e_out = cyc;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input logic [11:2] a, input logic [31:0] d, output int e_out);
        logic r, s;
        apb_wr(a, d, r, s, e_out);
    endtask

    // samp: register state after this edge is what the read returns.
    task automatic apb_rd(input logic [11:2] a, output logic rdy0, output logic rdy1,
                          output logic err, output logic [31:0] data, output int samp);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge pclkg); #1; penable = 1'b1;
        @(negedge pclkg); rdy0 = pready; samp = cyc;
        @(posedge pclkg); #1;
        @(negedge pclkg); rdy1 = pready; err = pslverr; data = prdata;
        @(posedge pclkg); #1; psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        logic r0, r1, er;
        logic [31:0] d;
        int s;
        #1 presetn = 1'b0;
        #1;
        total_cnt++; if (prdata !== 32'd0) $display("FAIL rst_prdata got=%0h exp=0", prdata); else pass_cnt++;
        total_cnt++; if (pready !== 1'b1) $display("FAIL rst_pready got=%0b exp=1", pready); else pass_cnt++;
        total_cnt++; if (pslverr !== 1'b0) $display("FAIL rst_pslverr got=%0b exp=0", pslverr); else pass_cnt++;
        total_cnt++; if (timer_irq !== 1'b0) $display("FAIL rst_irq got=%0b exp=0", timer_irq); else pass_cnt++;
        repeat (2) @(negedge pclkg);
        presetn = 1'b1;
        @(posedge pclkg); #1;
        for (int i = 0; i < 5; i++) begin
            apb_rd(10'(i), r0, r1, er, d, s);
            total_cnt++; if (d !== 32'd0) $display("FAIL rst_reg%0d got=%0h exp=0", i, d); else pass_cnt++;
            total_cnt++; if (r0 !== 1'b0 || r1 !== 1'b1) $display("FAIL rst_rd_wait%0d got=%0b%0b exp=01", i, r0, r1); else pass_cnt++;
            exp_reg[i] = 32'd0;
        end
    endtask

    task automatic test_regs();
        logic rdy, er, r0, r1;
        logic [31:0] d;
        int e, s, idx;
        for (int i = 0; i < 5; i++) begin
            d = $urandom;
            case (i)
                0: begin d[0] = 1'b0; exp_reg[0] = d & 32'h7; end
                1: exp_reg[1] = d;
                2: exp_reg[2] = d;
                3: exp_reg[3] = 32'd0;
                default: exp_reg[4] = d & 32'hFF;
            endcase
            apb_wr(10'(i), d, rdy, er, e);
            total_cnt++; if (rdy !== 1'b1 || er !== 1'b0) $display("FAIL wr%0d_resp got rdy=%0b err=%0b exp rdy=1 err=0", i, rdy, er); else pass_cnt++;
        end
        for (int i = 0; i < 8; i++) begin
            idx = $urandom_range(0, 4);
            idle($urandom_range(0, 2));
            apb_rd(10'(idx), r0, r1, er, d, s);
            total_cnt++; if (d !== exp_reg[idx]) $display("FAIL rd_reg%0d got=%0h exp=%0h", idx, d, exp_reg[idx]); else pass_cnt++;
            total_cnt++; if (r0 !== 1'b0 || r1 !== 1'b1 || er !== 1'b0) $display("FAIL rd_resp%0d got w=%0b r=%0b e=%0b exp 0 1 0", idx, r0, r1, er); else pass_cnt++;
        end
    endtask

    task automatic test_slverr();
        logic rdy, er, r0, r1;
        logic [31:0] d;
        int e, s;
        logic [11:2] bad [3];
        bad[0] = 10'd8;
        bad[1] = 10'd5;
        bad[2] = 10'($urandom_range(5, 1023));
        for (int i = 0; i < 3; i++) begin
            apb_wr(bad[i], $urandom, rdy, er, e);
            total_cnt++; if (rdy !== 1'b1 || er !== 1'b1) $display("FAIL err_wr%0d got rdy=%0b err=%0b exp 1 1", i, rdy, er); else pass_cnt++;
            apb_rd(bad[i], r0, r1, er, d, s);
            total_cnt++; if (r0 !== 1'b0 || r1 !== 1'b1 || er !== 1'b1 || d !== 32'd0)
                $display("FAIL err_rd%0d got w=%0b r=%0b e=%0b d=%0h exp 0 1 1 0", i, r0, r1, er, d); else pass_cnt++;
        end
        for (int i = 0; i < 5; i++) begin
            apb_rd(10'(i), r0, r1, er, d, s);
            total_cnt++; if (d !== exp_reg[i]) $display("FAIL err_nochg%0d got=%0h exp=%0h", i, d, exp_reg[i]); else pass_cnt++;
        end
    endtask

    task automatic start_timer(input int p, input int r, input longint v, input bit os, input bit ien);
        int e;
        wr(A_CTRL, 32'd0, e);
        wr(A_INT, 32'd1, e);
        wr(A_PRE, 32'(p), e);
        wr(A_RELOAD, 32'(r), e);
        wr(A_VALUE, 32'(v), e);
        wr(A_CTRL, {29'd0, os, ien, 1'b1}, e);
        m_e0 = e; m_p = p; m_r = r; m_vbase = v; m_kbase = 0; m_os = os; m_clr = e;
    endtask

    task automatic test_continuous();
        logic r0, r1, er, exp_irq;
        logic [31:0] d, ev;
        int s, e;
        start_timer(0, 3, 0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge pclkg); e = cyc;
            exp_irq = (e - 1 >= m_e0) ? irqf_at(e - 1) : 1'b0;
            total_cnt++; if (timer_irq !== exp_irq) $display("FAIL cont_irq@%0d got=%0b exp=%0b", e - m_e0, timer_irq, exp_irq); else pass_cnt++;
        end
        @(posedge pclkg); #1;
        for (int i = 0; i < 4; i++) begin
            apb_rd(A_VALUE, r0, r1, er, d, s);
            ev = 32'(val_at(s));
            total_cnt++; if (d !== ev) $display("FAIL cont_value%0d got=%0h exp=%0h", i, d, ev); else pass_cnt++;
        end
    endtask

    task automatic test_cont_random();
        logic r0, r1, er;
        logic [31:0] d, ev;
        int s;
        for (int run = 0; run < 2; run++) begin
            start_timer($urandom_range(0, 3), $urandom_range(0, 4), longint'($urandom_range(0, 5)), 1'b0, 1'b1);
            for (int i = 0; i < 8; i++) begin
                idle($urandom_range(0, 3));
                if (i % 2 == 0) begin
                    apb_rd(A_VALUE, r0, r1, er, d, s);
                    ev = 32'(val_at(s));
                end else begin
                    apb_rd(A_INT, r0, r1, er, d, s);
                    ev = {31'd0, irqf_at(s)};
                end
                total_cnt++; if (d !== ev) $display("FAIL rand%0d_rd%0d got=%0h exp=%0h", run, i, d, ev); else pass_cnt++;
            end
        end
    endtask

    task automatic test_oneshot();
        logic r0, r1, er;
        logic [31:0] d, ev;
        int s;
        start_timer(2, 1, 1, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) idle($urandom_range(0, 2));
            case (i % 3)
                0: begin apb_rd(A_VALUE, r0, r1, er, d, s); ev = 32'(val_at(s)); end
                1: begin apb_rd(A_CTRL, r0, r1, er, d, s); ev = {29'd0, 3'b100 | {2'b00, en_at(s)}}; end
                default: begin apb_rd(A_INT, r0, r1, er, d, s); ev = {31'd0, irqf_at(s)}; end
            endcase
            total_cnt++; if (d !== ev) $display("FAIL oneshot_rd%0d got=%0h exp=%0h", i, d, ev); else pass_cnt++;
        end
        total_cnt++; if (timer_irq !== 1'b0) $display("FAIL oneshot_irq_masked got=%0b exp=0", timer_irq); else pass_cnt++;
    endtask

    task automatic test_collision();
        logic r0, r1, er;
        logic [31:0] d, ev, x;
        int s, e, n;
        start_timer(3, 2, 0, 1'b0, 1'b1);
        n = 0;
        while (n < 100 && !(is_tick(cyc + 2) && reload_k(ticks_at(cyc + 2)))) begin idle(1); n++; end
        total_cnt++; if (n >= 100) $display("FAIL coll_align_a got=timeout exp=reload edge"); else pass_cnt++;
        wr(A_INT, 32'd1, e);
        m_clr = e;
        apb_rd(A_INT, r0, r1, er, d, s);
        ev = {31'd0, irqf_at(s)};
        total_cnt++; if (d !== ev) $display("FAIL coll_w1c_vs_set got=%0h exp=%0h", d, ev); else pass_cnt++;
        n = 0;
        while (n < 100 && !(is_tick(cyc + 1) && reload_k(ticks_at(cyc + 1)))) begin idle(1); n++; end
        wr(A_INT, 32'd1, e);
        m_clr = e;
        apb_rd(A_INT, r0, r1, er, d, s);
        ev = {31'd0, irqf_at(s)};
        total_cnt++; if (d !== ev) $display("FAIL coll_w1c_plain got=%0h exp=%0h", d, ev); else pass_cnt++;
        n = 0;
        while (n < 100 && !is_tick(cyc + 2)) begin idle(1); n++; end
        x = $urandom | 32'h100;
        wr(A_VALUE, x, e);
        m_vbase = longint'(x); m_kbase = ticks_at(e);
        apb_rd(A_VALUE, r0, r1, er, d, s);
        ev = 32'(val_at(s));
        total_cnt++; if (d !== ev) $display("FAIL coll_value_wr got=%0h exp=%0h", d, ev); else pass_cnt++;
        idle($urandom_range(5, 12));
        apb_rd(A_VALUE, r0, r1, er, d, s);
        ev = 32'(val_at(s));
        total_cnt++; if (d !== ev) $display("FAIL coll_value_run got=%0h exp=%0h", d, ev); else pass_cnt++;
    endtask

    task automatic test_psel_drop();
        logic r0, r1, er;
        logic [31:0] d;
        int s;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = A_RELOAD;
        @(posedge pclkg); #1; penable = 1'b1;
        @(negedge pclkg);
        total_cnt++; if (pready !== 1'b0) $display("FAIL drop_wait got=%0b exp=0", pready); else pass_cnt++;
        @(posedge pclkg); #1; psel = 1'b0; penable = 1'b0;
        @(negedge pclkg);
        total_cnt++; if (pready !== 1'b1 || prdata !== 32'd0 || pslverr !== 1'b0)
            $display("FAIL drop_pend got rdy=%0b d=%0h e=%0b exp 1 0 0", pready, prdata, pslverr); else pass_cnt++;
        @(posedge pclkg); #1;
        apb_rd(A_RELOAD, r0, r1, er, d, s);
        total_cnt++; if (d !== 32'd2 || r0 !== 1'b0 || r1 !== 1'b1) $display("FAIL drop_next got d=%0h w=%0b r=%0b exp 2 0 1", d, r0, r1); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic r0, r1, er;
        logic [31:0] d;
        int s;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = A_RELOAD;
        @(posedge pclkg); #1; penable = 1'b1;
        @(posedge pclkg); #1;
        total_cnt++; if (prdata !== 32'd2) $display("FAIL mid_pend_data got=%0h exp=2", prdata); else pass_cnt++;
        presetn = 1'b0; penable = 1'b0;
        #1;
        total_cnt++; if (prdata !== 32'd0 || pready !== 1'b1 || pslverr !== 1'b0 || timer_irq !== 1'b0)
            $display("FAIL mid_async got d=%0h rdy=%0b e=%0b irq=%0b exp 0 1 0 0", prdata, pready, pslverr, timer_irq); else pass_cnt++;
        psel = 1'b0;
        repeat (2) @(negedge pclkg);
        presetn = 1'b1;
        @(posedge pclkg); #1;
        apb_rd(A_CTRL, r0, r1, er, d, s);
        total_cnt++; if (d !== 32'd0 || r0 !== 1'b0 || r1 !== 1'b1) $display("FAIL mid_ctrl got d=%0h w=%0b r=%0b exp 0 0 1", d, r0, r1); else pass_cnt++;
        idle(3);
        apb_rd(A_VALUE, r0, r1, er, d, s);
        total_cnt++; if (d !== 32'd0) $display("FAIL mid_value got=%0h exp=0", d); else pass_cnt++;
        apb_rd(A_RELOAD, r0, r1, er, d, s);
        total_cnt++; if (d !== 32'd0) $display("FAIL mid_reload got=%0h exp=0", d); else pass_cnt++;
    endtask

    initial begin
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; presetn = 1'b1;
        test_reset();
        test_regs();
        test_slverr();
        test_continuous();
        test_cont_random();
        test_oneshot();
        test_collision();
        test_psel_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bt_timer_apb_slv.md
BT_TIMER_APB_SLV -- requirements
Module: bt_timer_apb_slv

Interface
REQ-001 Parameter: PRESCALE_W, default 8, width of the PRESCALE register and the prescaler counter (1..16).
REQ-002 pclkg  in  1  sole clock; all state updates on rising edge.
REQ-003 presetn  in  1  reset, asynchronous assert, active-low.
REQ-004 psel  in  1  APB slave select.
REQ-005 penable  in  1  APB access phase.
REQ-006 pwrite  in  1  1=write, 0=read.
REQ-007 paddr  in  [11:2]  word address.
REQ-008 pwdata  in  32  write data.
REQ-009 prdata  out  32  read data.
REQ-010 pready  out  1  transfer complete.
REQ-011 pslverr  out  1  transfer error.
REQ-012 timer_irq  out  1  level interrupt, registered.

Function
REQ-013 Register map (byte offset): 0x000 CTRL {bit0 EN, bit1 IRQEN, bit2 ONESHOT}; 0x004 VALUE[31:0]; 0x008 RELOAD[31:0]; 0x00C INTSTATUS {bit0 IRQF}, write-1-to-clear; 0x010 PRESCALE[PRESCALE_W-1:0]; unused bits read 0, writes to them ignored.
REQ-014 Write completes zero-wait: pready=1 in the access cycle; register updated at the edge ending that cycle (psel&penable&pwrite).
REQ-015 Read has exactly one wait state: FSM IDLE->RD_PEND on psel&penable&!pwrite with pready=0; RD_PEND asserts pready=1 with prdata = register value sampled at the end of the first access cycle; RD_PEND->IDLE unconditionally.
REQ-016 psel deasserted while in RD_PEND: return to IDLE, prdata=0, pready=1.
REQ-017 prdata=0 in every cycle except the RD_PEND completion cycle.
REQ-018 Offset >0x010: pslverr=1 only in the completing cycle (pready=1); write ignored; read returns 0; same wait-state rules as mapped accesses.
REQ-019 pslverr=0 in all other cycles; pready=1 whenever no read is pending.
REQ-020 Prescaler: while EN=1, counter increments each cycle; tick when counter==PRESCALE, counter then wraps to 0; while EN=0, counter held at 0, no ticks.
REQ-021 On tick: if VALUE!=0, VALUE<=VALUE-1; if VALUE==0, IRQF<=1 and VALUE<=RELOAD, except ONESHOT=1 -> VALUE stays 0 and EN<=0.
REQ-022 Period in continuous mode = (RELOAD+1)*(PRESCALE+1) cycles; PRESCALE=0 -> tick every cycle.
REQ-023 APB write to VALUE in a tick cycle: written value wins, tick decrement discarded.
REQ-024 APB write to CTRL in the cycle a one-shot clears EN: written value wins.
REQ-025 INTSTATUS W1C in the same cycle IRQF is set by a tick: set wins, IRQF=1.
REQ-026 timer_irq <= IRQF & IRQEN, one cycle after either changes.
REQ-027 VALUE and RELOAD are unsigned 32-bit; no wrap below 0 (0 triggers reload, never 0xFFFFFFFF).

Reset
REQ-028 presetn low: CTRL, VALUE, RELOAD, IRQF, PRESCALE, prescaler counter = 0; FSM=IDLE; prdata=0, pready=1, pslverr=0, timer_irq=0 immediately, without a clock edge.
REQ-029 Reset asserted during RD_PEND or mid-count aborts the operation; after release, first access behaves as from IDLE.

Verification
REQ-030 Write RELOAD=3, PRESCALE=0, CTRL=0x3 -> VALUE counts 0->3,2,1,0; IRQF set every 4 cycles; timer_irq high 1 cycle after first IRQF set.
REQ-031 PRESCALE=2, RELOAD=1, VALUE=1, CTRL=0x5 -> VALUE decrements every 3 cycles; after reaching 0, next tick sets IRQF, EN reads 0, VALUE stays 0.
REQ-032 Read 0x008 after writing 0xDEADBEEF -> pready=0 one cycle, then pready=1, prdata=0xDEADBEEF, pslverr=0.
REQ-033 Read and write at offset 0x020 -> pslverr=1 on completion, prdata=0, no register changes.
REQ-034 W1C INTSTATUS in the exact cycle a tick reloads -> IRQF remains 1; VALUE write coinciding with tick -> written value read back.
REQ-035 presetn pulsed low during RD_PEND with count running -> all outputs at reset values asynchronously; subsequent read of CTRL returns 0x0.
